// File: rtl/irrigation_display_pkg.sv
// Shared definitions for the irrigation controller's 7-segment display path:
// segment bit order, scan states and the segment codes the decoders emit.
package irrigation_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Bit positions inside a 7-bit segment code (bit6 = a ... bit0 = g)
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    typedef enum logic {BLANK, ON} scan_state_t;

    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_DASH = 7'h01;
    localparam logic [6:0] SEG_L    = 7'h0E;
    localparam logic [6:0] SEG_H    = 7'h37;

    // Board pins are common-anode, so a lit segment is driven low.
    function automatic logic [6:0] seg_to_pins(input logic [6:0] code);
        return ~code;
    endfunction

endpackage

// File: rtl/display_scanner_slot_timer.sv
// Digit-slot timer: counts REFRESH_DIV cycles per slot and tracks whether the
// slot is still in its leading blank gap.
module slot_timer
    import irrigation_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic clk,
    input  logic reset,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] count, count_next;
    scan_state_t   state, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= BLANK;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

    // State follows the counter value it will hold next, keeping both aligned.
    always_comb begin
        slot_end   = (count == CW'(REFRESH_DIV - 1));
        count_next = slot_end ? '0 : count + CW'(1);
        state_next = (count_next < CW'(BLANK_CYCLES)) ? BLANK : ON;
        in_blank   = (state == BLANK);
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with a double-buffered
// frame interface; new frames only take effect at the end of a digit4 slot.
module display_scanner
    import irrigation_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    output logic       frame_ready,
    input  logic [6:0] seg_digit1,
    input  logic [6:0] seg_digit2,
    input  logic [6:0] seg_digit3,
    input  logic [6:0] seg_digit4,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       digit1,
    output logic       digit2,
    output logic       digit3,
    output logic       digit4
);

    logic                         slot_end;
    logic                         in_blank;
    logic [1:0]                   index;
    logic [NUM_DIGITS-1:0][6:0]   active;
    logic [NUM_DIGITS-1:0][6:0]   pending;
    logic                         pending_full, pending_full_next;
    logic                         accept, boundary, promote;
    logic [6:0]                   seg_q;
    logic [NUM_DIGITS-1:0]        dig_q;

    slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .reset    (reset),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    // Ready is low whenever pending is full, so accept and promote never coincide.
    always_comb begin
        accept            = frame_valid && frame_ready;
        boundary          = slot_end && (index == 2'(NUM_DIGITS - 1));
        promote           = boundary && pending_full;
        pending_full_next = pending_full;
        if (promote)
            pending_full_next = 1'b0;
        if (accept)
            pending_full_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index        <= '0;
            pending_full <= 1'b0;
            frame_ready  <= 1'b0;
            active       <= {NUM_DIGITS{SEG_BLANK}};
            seg_q        <= seg_to_pins(SEG_BLANK);
            dig_q        <= '1;
        end else begin
            if (slot_end)
                index <= index + 2'd1;
            pending_full <= pending_full_next;
            frame_ready  <= !pending_full_next;
            if (promote)
                active <= pending;
            seg_q <= in_blank ? seg_to_pins(SEG_BLANK) : seg_to_pins(active[index]);
            dig_q <= in_blank ? '1 : ~(NUM_DIGITS'(1) << index);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pending <= {seg_digit4, seg_digit3, seg_digit2, seg_digit1};
    end

    assign a = seg_q[SEG_A];
    assign b = seg_q[SEG_B];
    assign c = seg_q[SEG_C];
    assign d = seg_q[SEG_D];
    assign e = seg_q[SEG_E];
    assign f = seg_q[SEG_F];
    assign g = seg_q[SEG_G];

    assign digit1 = dig_q[0];
    assign digit2 = dig_q[1];
    assign digit3 = dig_q[2];
    assign digit4 = dig_q[3];

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display, consuming the segment codes the irrigation controller produces. It holds one frame of four segment patterns and scans digit1..digit4 in turn, with a blanking gap between digits to prevent ghosting. New frames arrive over a valid/ready handshake and are double-buffered, so a frame change never tears mid-scan. It replaces static digit enables at the top level and sits between the level/irrigation decoders and the board pins.

## Interface
- REFRESH_DIV, 12500: clock cycles per digit slot, blank portion included (50 MHz gives a 4 kHz slot and a 1 kHz frame).
- BLANK_CYCLES, 250: cycles at the start of each slot with all digits off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- frame_valid  in  1  producer has a frame on seg_digit1..seg_digit4.
- frame_ready  out  1  block can accept a frame; transfer occurs when valid and ready are both high on a rising edge.
- seg_digit1..seg_digit4  in  7 each  active-high segment code, bit6=a … bit0=g.
- a, b, c, d, e, f, g  out  1 each  segment pins, active-low (0 = lit).
- digit1, digit2, digit3, digit4  out  1 each  digit enables, active-low (0 = digit on).

## Operation
- Registers: active frame (4×7), pending frame (4×7) with pending_full flag, slot counter (0..REFRESH_DIV-1), 2-bit digit index.
- Per-slot state machine:
  - BLANK: counter < BLANK_CYCLES; all digit enables 1, all segments 1.
  - ON: otherwise; the selected digit's enable is 0 and its segments carry the inverted active code.
- When the counter reaches REFRESH_DIV-1, it wraps to 0 and the index advances 1→2→3→4→1.
- Frame boundary is the last cycle of the digit4 slot. On that cycle, if pending_full, then active ← pending and pending_full ← 0.
- Accept: when frame_valid && frame_ready, pending ← inputs and pending_full ← 1.
- frame_ready = !pending_full, registered. At most one accept is outstanding.
- Accept on the boundary cycle with pending empty: the frame lands in pending and becomes active at the next boundary, one full frame later.
- Boundary with pending full: ready is 0 that cycle, so no accept can coincide; ready returns to 1 on the following cycle.
- A code of 0 displays blank. Codes are not validated; all 7 bits pass through.
- Reset, including mid-scan: counter 0, index digit1, state BLANK, active frame all-zero, pending_full 0. All outputs go inactive within one cycle.

## Timing
- Reset values: a..g = 1, digit1..digit4 = 1, frame_ready = 0 while reset is high and 1 on the first cycle after reset deasserts.
- All outputs are registered, one cycle after the internal counter/index state.
- After reset release:
  - digit1 first goes low at cycle BLANK_CYCLES+1.
  - Each digit stays on for REFRESH_DIV-BLANK_CYCLES cycles.
  - Frame period is 4×REFRESH_DIV cycles.
- At most one digit enable is low in any cycle. A digit enable is never low in the same cycle that segments change to another digit's code; the blank gap guarantees this.
- Accept-to-display latency: from the accept edge to the next boundary plus one cycle. The maximum is 4×REFRESH_DIV+1 cycles.

## Structure
- Shared package irrigation_display_pkg:
  - NUM_DIGITS = 4.
  - SEG_BLANK = 7'b0000000.
  - Segment bit-order constants.
  - Scan state enum {BLANK, ON}.
  - Segment codes used by the level/irrigation decoders.
- One sub-module, slot_timer: the slot counter plus BLANK/ON state, parameterised by REFRESH_DIV and BLANK_CYCLES. It emits slot_end and in_blank. Everything else lives in display_scanner.

## Test plan
Unless stated, REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset, then 40 idle cycles:
  - digit1..4 never low before cycle 3.
  - a..g stay 1 throughout (blank frame).
  - frame_ready = 1 from cycle 1.
- Accept {7'h7E, 7'h30, 7'h6D, 7'h79} at cycle 1:
  - frame_ready drops for cycles 2..32.
  - From cycle 33 onward, digit1 is low during its ON window with a..g = 7'b0000001.
  - Each digit shows its inverted code in order 1→2→3→4.
- Accept frame A, then hold frame_valid high with frame B:
  - B is accepted only after the boundary that promotes A.
  - A is displayed for one full frame before B.
- Assert frame_valid with a new frame exactly on a boundary cycle while pending is empty:
  - The frame is accepted.
  - It is displayed only after the following boundary, not the current one.
- Assert reset mid-slot while digit3 is on with pending_full = 1:
  - Next cycle, all outputs are 1, frame_ready is 0 during reset and 1 afterwards.
  - The pending frame is discarded.
- Continuous scan for 10 frames:
  - The assertion "at most one digit enable low" holds throughout.
  - Each digit is low for exactly 6 cycles per slot.
